data_path: RTL and testbench

- 32-bit single-bus CPU datapath: register file R0–R15, HI, LO, PC, IR, MAR, MDR, Y, and a 64-bit Z split into ZHigh/ZLow.
- A 5-bit-opcode ALU computes Y (op) bus into Z.
- An external control unit or testbench drives the per-register in/out strobes each cycle.
- Memory data arrives on Mdatain and is loaded into MDR when Read is high.

---
 rtl/data_path_if.sv | 35 +++
 rtl/data_path.sv | 130 +++++++++++++
 tb/tb_data_path.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// Control/data bundle for the single-bus CPU datapath: bus source selects,
// register load enables, memory data in, and the observable register outputs.
interface data_path_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   Mdatain;
    logic [4:0]         opcode;
    logic               Read;
    logic               PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    // Bit i of Rout/Rin is the Ri out-select / load enable.
    logic [15:0]        Rout;
    logic [15:0]        Rin;
    logic               HIin, LOin, PCin, IRin, MARin, MDRin, Yin;
    logic               ZHighIn, ZLowIn, IncPC, Cin;
    logic [WIDTH-1:0]   BusMuxOut;
    logic [WIDTH-1:0]   IRdata;
    logic [WIDTH-1:0]   MARdata;
    logic [2*WIDTH-1:0] Zdata;

    modport master (
        output Mdatain, opcode, Read,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Rout, Rin,
        output HIin, LOin, PCin, IRin, MARin, MDRin, Yin,
        output ZHighIn, ZLowIn, IncPC, Cin,
        input  BusMuxOut, IRdata, MARdata, Zdata
    );

    modport slave (
        input  Mdatain, opcode, Read,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Rout, Rin,
        input  HIin, LOin, PCin, IRin, MARin, MDRin, Yin,
        input  ZHighIn, ZLowIn, IncPC, Cin,
        output BusMuxOut, IRdata, MARdata, Zdata
    );
endinterface

// File: rtl/data_path.sv
// 32-bit single-bus CPU datapath: R0-R15, HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z and ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier/divider for MUL and DIV.
module data_path #(
    parameter int WIDTH = 32
) (
    input logic        clock,
    input logic        clear,
    data_path_if.slave bus_if
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_MUL  = 5'b01111,
        OP_DIV  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } alu_op_e;

    logic [WIDTH-1:0]   r_q [16];
    logic [WIDTH-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
    logic [2*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_res;
    logic [2*WIDTH-1:0] rot;
    logic [4:0]         shamt;

    // Sources are written lowest priority first so R0 ends up winning; an x/z
    // select fails the if-test and behaves as deasserted.
    // NOTE: every always_comb output gets a default first, otherwise an
    // unassigned path infers a latch.
    always_comb begin
        bus = '0;
        if (bus_if.MDRout)   bus = mdr_q;
        if (bus_if.PCout)    bus = pc_q;
        if (bus_if.Zlowout)  bus = z_q[WIDTH-1:0];
        if (bus_if.Zhighout) bus = z_q[2*WIDTH-1:WIDTH];
        if (bus_if.LOout)    bus = lo_q;
        if (bus_if.HIout)    bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (bus_if.Rout[i]) bus = r_q[i];
        end
    end

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WIDTH-1:0] mul_a, mul_b;
    logic signed [WIDTH-1:0]   div_a, div_b;
    assign mul_a = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    assign mul_b = {{WIDTH{bus[WIDTH-1]}}, bus};
    assign div_a = y_q;
    assign div_b = bus;
`endif

    always_comb begin
        alu_res = '0;
        rot     = '0;
        shamt   = bus[4:0];
        case (bus_if.opcode)
            OP_ADD:  alu_res[WIDTH-1:0] = y_q + bus + {{(WIDTH-1){1'b0}}, bus_if.Cin};
            OP_SUB:  alu_res[WIDTH-1:0] = y_q - bus;
            OP_AND:  alu_res[WIDTH-1:0] = y_q & bus;
            OP_OR:   alu_res[WIDTH-1:0] = y_q | bus;
            OP_ROR: begin
                rot = {y_q, y_q} >> shamt;
                alu_res[WIDTH-1:0] = rot[WIDTH-1:0];
            end
            OP_ROL: begin
                rot = {y_q, y_q} << shamt;
                alu_res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
            end
            OP_SHR:  alu_res[WIDTH-1:0] = y_q >> shamt;
            OP_SHRA: alu_res[WIDTH-1:0] = $signed(y_q) >>> shamt;
            OP_SHL:  alu_res[WIDTH-1:0] = y_q << shamt;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  alu_res = mul_a * mul_b;
            OP_DIV: begin
                // Divide-by-zero returns all-ones quotient and A as remainder.
                if (bus == '0) alu_res = {y_q, {WIDTH{1'b1}}};
                else           alu_res = {div_a % div_b, div_a / div_b};
            end
`endif
            OP_NEG:  alu_res[WIDTH-1:0] = -y_q;
            OP_NOT:  alu_res[WIDTH-1:0] = ~y_q;
            default: alu_res = '0;
        endcase
    end

    // NOTE: the register file is a small array of flops that must read zero
    // after clear, so it is reset here like every other register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (bus_if.Rin[i]) r_q[i] <= bus;
            end
            if (bus_if.HIin)  hi_q  <= bus;
            if (bus_if.LOin)  lo_q  <= bus;
            if (bus_if.IRin)  ir_q  <= bus;
            if (bus_if.MARin) mar_q <= bus;
            if (bus_if.Yin)   y_q   <= bus;
            if (bus_if.MDRin) mdr_q <= bus_if.Read ? bus_if.Mdatain : bus;
            if (bus_if.PCin)       pc_q <= bus;
            else if (bus_if.IncPC) pc_q <= pc_q + WIDTH'(1);
            if (bus_if.ZHighIn) z_q[2*WIDTH-1:WIDTH] <= alu_res[2*WIDTH-1:WIDTH];
            if (bus_if.ZLowIn)  z_q[WIDTH-1:0]       <= alu_res[WIDTH-1:0];
        end
    end

    assign bus_if.BusMuxOut = bus;
    assign bus_if.IRdata    = ir_q;
    assign bus_if.MARdata   = mar_q;
    assign bus_if.Zdata     = z_q;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus random ALU ops
// checked against an arithmetic reference model.
module tb_data_path;

    logic clock = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    data_path_if #(.WIDTH(32)) dp ();
    data_path #(.WIDTH(32)) dut (.clock(clock), .clear(clear), .bus_if(dp.slave));

    always #5 clock = ~clock;

    // Reference ALU written from the operation definitions using integer arithmetic.
    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        longint unsigned m  = 64'h1_0000_0000;
        longint unsigned ua = a;
        longint unsigned ub = b;
        int              s  = int'(ub % 32);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          q, r;
        logic [31:0]     t  = a;
        case (op)
            5'b00011: return (ua + ub + cin) % m;
            5'b00100: return (ua + m - ub) % m;
            5'b00101: return {32'b0, a & b};
            5'b00110: return {32'b0, a | b};
            5'b00111: begin repeat (s) t = {t[0], t[31:1]}; return {32'b0, t}; end
            5'b01000: begin repeat (s) t = {t[30:0], t[31]}; return {32'b0, t}; end
            5'b01001: return ua / (64'd1 << s);
            5'b01010: return {32'b0, 32'(sa >>> s)};
            5'b01011: return (ua * (64'd1 << s)) % m;
`ifdef DATAPATH_MULDIV_EN
            5'b01111: return 64'(sa * sb);
            5'b10000: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                if ((sa < 0) != (sb < 0)) q = -q;
                r = sa - q * sb;
                return {32'(r), 32'(q)};
            end
`endif
            5'b10001: return (m - ua) % m;
            5'b10010: return (m - 1) - ua;
            default:  return 64'd0;
        endcase
    endfunction

    task automatic idle();
        dp.Mdatain = '0; dp.opcode = '0; dp.Read = 0;
        dp.PCout = 0; dp.Zhighout = 0; dp.Zlowout = 0; dp.MDRout = 0; dp.HIout = 0; dp.LOout = 0;
        dp.Rout = '0; dp.Rin = '0;
        dp.HIin = 0; dp.LOin = 0; dp.PCin = 0; dp.IRin = 0; dp.MARin = 0; dp.MDRin = 0; dp.Yin = 0;
        dp.ZHighIn = 0; dp.ZLowIn = 0; dp.IncPC = 0; dp.Cin = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        dp.Read = 1; dp.MDRin = 1; dp.Mdatain = v;
        tick();
        idle();
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic cin);
        load_mdr(a);
        dp.MDRout = 1; dp.Yin = 1;
        tick();
        load_mdr(b);
        dp.MDRout = 1; dp.opcode = op; dp.Cin = cin; dp.ZHighIn = 1; dp.ZLowIn = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        clear = 1;
        #3;
        n_checks++; if (dp.BusMuxOut !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", dp.BusMuxOut); end
        n_checks++; if (dp.IRdata !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", dp.IRdata); end
        n_checks++; if (dp.MARdata !== 32'h0) begin n_fail++; $display("FAIL reset_mar: got %h want 0", dp.MARdata); end
        n_checks++; if (dp.Zdata !== 64'h0) begin n_fail++; $display("FAIL reset_z: got %h want 0", dp.Zdata); end
        @(negedge clock);
        clear = 0;
        tick();
    endtask

    task automatic test_neg();
        load_mdr(32'h12);
        dp.MDRout = 1; dp.Rin[0] = 1; tick(); idle();
        load_mdr(32'h7F);
        dp.MDRout = 1; dp.Rin[5] = 1; tick(); idle();
        dp.Rout[5] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'h7F) begin n_fail++; $display("FAIL neg_r5_init: got %h want 7f", dp.BusMuxOut); end
        idle();
        dp.Rout[0] = 1; dp.Yin = 1; tick(); idle();
        dp.opcode = 5'b10001; dp.ZLowIn = 1; tick(); idle();
        dp.Zlowout = 1; dp.Rin[5] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'hFFFF_FFEE) begin n_fail++; $display("FAIL neg_bus: got %h want ffffffee", dp.BusMuxOut); end
        tick(); idle();
        dp.Rout[5] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'hFFFF_FFEE) begin n_fail++; $display("FAIL neg_r5: got %h want ffffffee", dp.BusMuxOut); end
        idle();
    endtask

    task automatic test_add_sub();
        run_op(32'd5, 32'd7, 5'b00011, 1'b1);
        n_checks++; if (dp.Zdata !== 64'hD) begin n_fail++; $display("FAIL add: got %h want d", dp.Zdata); end
        run_op(32'd5, 32'd7, 5'b00100, 1'b0);
        n_checks++; if (dp.Zdata !== 64'hFFFF_FFFE) begin n_fail++; $display("FAIL sub: got %h want fffffffe", dp.Zdata); end
    endtask

    task automatic test_shifts();
        logic [4:0]  ops [5] = '{5'b01001, 5'b01010, 5'b00111, 5'b01000, 5'b01011};
        logic [31:0] exp [5] = '{32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 32'h0000_0003, 32'h0000_0002};
        for (int i = 0; i < 5; i++) begin
            run_op(32'h8000_0001, 32'd1, ops[i], 1'b0);
            n_checks++;
            if (dp.Zdata[31:0] !== exp[i]) begin
                n_fail++; $display("FAIL shift op=%b: got %h want %h", ops[i], dp.Zdata[31:0], exp[i]);
            end
        end
        run_op(32'h8765_4321, 32'd32, 5'b01010, 1'b0);
        n_checks++; if (dp.Zdata[31:0] !== 32'h8765_4321) begin n_fail++; $display("FAIL shift_zero_amt: got %h want 87654321", dp.Zdata[31:0]); end
    endtask

    task automatic test_pc_ir();
        load_mdr(32'h7);
        dp.MDRout = 1; dp.PCin = 1; tick(); idle();
        dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'h7) begin n_fail++; $display("FAIL pc_load: got %h want 7", dp.BusMuxOut); end
        tick(); idle();
        n_checks++; if (dp.MARdata !== 32'h7) begin n_fail++; $display("FAIL mar: got %h want 7", dp.MARdata); end
        dp.PCout = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'h8) begin n_fail++; $display("FAIL pc_inc: got %h want 8", dp.BusMuxOut); end
        load_mdr(32'h8A1B_8000);
        dp.MDRout = 1; dp.IRin = 1; tick(); idle();
        n_checks++; if (dp.IRdata !== 32'h8A1B_8000) begin n_fail++; $display("FAIL ir: got %h want 8a1b8000", dp.IRdata); end
        load_mdr(32'hFFFF_FFFF);
        dp.MDRout = 1; dp.PCin = 1; tick(); idle();
        dp.IncPC = 1; tick(); idle();
        dp.PCout = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", dp.BusMuxOut); end
        load_mdr(32'h100);
        dp.MDRout = 1; dp.PCin = 1; dp.IncPC = 1; tick(); idle();
        dp.PCout = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'h100) begin n_fail++; $display("FAIL pc_priority: got %h want 100", dp.BusMuxOut); end
        idle();
    endtask

    task automatic test_bus();
        logic [31:0] va = $urandom;
        logic [31:0] vb = $urandom;
        load_mdr(va); dp.MDRout = 1; dp.Rin[1] = 1; tick(); idle();
        load_mdr(vb); dp.MDRout = 1; dp.Rin[2] = 1; dp.Rin[3] = 1; dp.HIin = 1; tick(); idle();
        dp.Rout[1] = 1; dp.Rout[2] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== va) begin n_fail++; $display("FAIL bus_prio_r: got %h want %h", dp.BusMuxOut, va); end
        idle(); dp.Rout[3] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== vb) begin n_fail++; $display("FAIL multi_load: got %h want %h", dp.BusMuxOut, vb); end
        idle(); dp.HIout = 1; dp.MDRout = 1; dp.Rout[4] = 1'bx; #1;
        n_checks++; if (dp.BusMuxOut !== vb) begin n_fail++; $display("FAIL bus_hi: got %h want %h", dp.BusMuxOut, vb); end
        idle(); #1;
        n_checks++; if (dp.BusMuxOut !== 32'h0) begin n_fail++; $display("FAIL bus_none: got %h want 0", dp.BusMuxOut); end
        dp.Rout[2] = 1; dp.Rin[2] = 1; dp.MDRout = 1; tick(); idle();
        dp.Rout[2] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== vb) begin n_fail++; $display("FAIL self_reload: got %h want %h", dp.BusMuxOut, vb); end
        idle(); dp.Rout[1] = 1; dp.MDRin = 1; dp.Read = 0; dp.Mdatain = ~va; tick(); idle();
        dp.MDRout = 1; #1;
        n_checks++; if (dp.BusMuxOut !== va) begin n_fail++; $display("FAIL mdr_from_bus: got %h want %h", dp.BusMuxOut, va); end
        idle();
    endtask

    task automatic test_muldiv();
        logic [63:0] exp_mul, exp_div;
`ifdef DATAPATH_MULDIV_EN
        exp_mul = 64'hFFFF_FFFF_FFFF_FFF4;
        exp_div = 64'hFFFF_FFFF_FFFF_FFFD;
`else
        exp_mul = 64'h0;
        exp_div = 64'h0;
`endif
        run_op(-32'sd3, 32'd4, 5'b01111, 1'b0);
        n_checks++; if (dp.Zdata !== exp_mul) begin n_fail++; $display("FAIL mul: got %h want %h", dp.Zdata, exp_mul); end
        run_op(-32'sd7, 32'd2, 5'b10000, 1'b0);
        n_checks++; if (dp.Zdata !== exp_div) begin n_fail++; $display("FAIL div: got %h want %h", dp.Zdata, exp_div); end
    endtask

    task automatic test_random();
        logic [4:0]  ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                  5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd31};
        logic [31:0] a, b;
        logic [4:0]  op;
        logic        cin;
        logic [63:0] exp;
        for (int i = 0; i < 60; i++) begin
            op  = ops[$urandom_range(0, 14)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (op == 5'd16 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            cin = 1'($urandom_range(0, 1));
            exp = alu_ref(op, a, b, cin);
            run_op(a, b, op, cin);
            n_checks++;
            if (dp.Zdata !== exp) begin
                n_fail++; $display("FAIL random op=%b a=%h b=%h: got %h want %h", op, a, b, dp.Zdata, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        load_mdr(32'h55);
        dp.MDRout = 1; dp.Rin[0] = 1; tick(); idle();
        run_op(32'h1234, 32'h1, 5'b00011, 1'b0);
        @(posedge clock); #2;
        clear = 1; #1;
        n_checks++; if (dp.Zdata !== 64'h0) begin n_fail++; $display("FAIL mid_reset_z: got %h want 0", dp.Zdata); end
        n_checks++; if (dp.IRdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ir: got %h want 0", dp.IRdata); end
        n_checks++; if (dp.MARdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_mar: got %h want 0", dp.MARdata); end
        dp.Rout[0] = 1; #1;
        n_checks++; if (dp.BusMuxOut !== 32'h0) begin n_fail++; $display("FAIL mid_reset_r0: got %h want 0", dp.BusMuxOut); end
        @(negedge clock);
        clear = 0;
        idle();
        dp.Yin = 1; dp.MDRout = 1; tick(); idle();
        dp.opcode = 5'b10010; dp.ZLowIn = 1; tick(); idle();
        n_checks++; if (dp.Zdata !== 64'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_reset_y: got %h want ffffffff", dp.Zdata); end
    endtask

    initial begin
        clear = 1;
        test_reset();
        test_neg();
        test_add_sub();
        test_shifts();
        test_pc_ir();
        test_bus();
        test_muldiv();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
